// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: soft-start then bang-bang duty regulation with overcurrent fault latch.
// Ports: clock/reset (sync, active-high); start/stop level requests; fb comparator (1 = lower duty);
//        ocp overcurrent; fault_clr leaves FAULT; duty/en/state/fault are registered outputs.
module pwm_duty_sequencer #(
  parameter int TICK_DIV  = 10000,
  parameter int SS_TARGET = 256,
  parameter int DUTY_MIN  = 16,
  parameter int DUTY_MAX  = 480
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       fb,
  input  logic       ocp,
  input  logic       fault_clr,
  output logic [8:0] duty,
  output logic       en,
  output logic [1:0] state,
  output logic       fault
);
  typedef enum logic [1:0] {IDLE, SOFTSTART, REGULATE, FAULT} st_t;
  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);
  localparam logic [8:0] SS = 9'(SS_TARGET);
  localparam logic [8:0] MIN = 9'(DUTY_MIN);
  localparam logic [8:0] MAX = 9'(DUTY_MAX);
  st_t st, st_n;
  logic [8:0] duty_n;
  logic en_n, fault_n, run, tick;
  logic [15:0] cnt, cnt_n;
  assign state = st;
  always_comb begin
    run = st == SOFTSTART || st == REGULATE;
    tick = run && cnt == LAST;
    st_n = st;
    duty_n = duty;
    en_n = en;
    fault_n = fault;
    cnt_n = run ? (tick ? '0 : cnt + 16'd1) : '0;
    if (st == FAULT) begin
      duty_n = '0;
      en_n = 1'b0;
      if (fault_clr && !ocp) begin
        st_n = IDLE;
        fault_n = 1'b0;
      end
    end else if (ocp) begin
      st_n = FAULT;
      duty_n = '0;
      en_n = 1'b0;
      fault_n = 1'b1;
      cnt_n = '0;
    end else if (st == IDLE) begin
      duty_n = '0;
      en_n = 1'b0;
      fault_n = 1'b0;
      if (start && !stop) begin
        st_n = SOFTSTART;
        en_n = 1'b1;
      end
    end else if (stop) begin
      st_n = IDLE;
      duty_n = '0;
      en_n = 1'b0;
      cnt_n = '0;
    end else if (tick) begin
      if (st == SOFTSTART) begin
        duty_n = duty + 9'd1;
        if (duty_n == SS) st_n = REGULATE;
      end else begin
        duty_n = fb ? (duty <= MIN ? MIN : duty - 9'd1) : (duty >= MAX ? MAX : duty + 9'd1);
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st <= IDLE;
      duty <= '0;
      en <= 1'b0;
      fault <= 1'b0;
      cnt <= '0;
    end else begin
      st <= st_n;
      duty <= duty_n;
      en <= en_n;
      fault <= fault_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: doc/pwm_duty_sequencer.md
PWM_DUTY_SEQUENCER -- requirements
Module: pwm_duty_sequencer

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 10000, clock cycles per control tick (range 2..65535).
REQ-002 SHALL provide parameter SS_TARGET, default 256, duty at which soft-start ends.
REQ-003 SHALL provide parameter DUTY_MIN, default 16, lower regulation clamp.
REQ-004 SHALL provide parameter DUTY_MAX, default 480, upper regulation clamp; constraint DUTY_MIN <= SS_TARGET <= DUTY_MAX <= 511.
REQ-005 SHALL have port clock  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  level request to begin soft-start from IDLE.
REQ-008 SHALL have port stop  input  1  level request to shut down to IDLE.
REQ-009 SHALL have port fb  input  1  feedback comparator; 1 = output above target (decrease duty), 0 = below (increase).
REQ-010 SHALL have port ocp  input  1  overcurrent flag, synchronous to clock.
REQ-011 SHALL have port fault_clr  input  1  request to leave FAULT.
REQ-012 SHALL have port duty  output  9  duty command to the PWM generator.
REQ-013 SHALL have port en  output  1  power-stage enable.
REQ-014 SHALL have port state  output  2  current state encoding.
REQ-015 SHALL have port fault  output  1  latched fault indicator.

Function
REQ-016 SHALL implement states IDLE=0, SOFTSTART=1, REGULATE=2, FAULT=3; all outputs registered, updating the cycle after the causing input.
REQ-017 SHALL keep a 16-bit tick counter counting 0..TICK_DIV-1, asserting internal tick in the cycle count==TICK_DIV-1, then wrapping to 0.
REQ-018 SHALL run the tick counter only in SOFTSTART and REGULATE; hold it at 0 in IDLE and FAULT; clear it on entry to SOFTSTART.
REQ-019 SHALL, in IDLE, drive duty=0, en=0, fault=0.
REQ-020 SHALL, in IDLE with start=1 and stop=0 and ocp=0, enter SOFTSTART with duty=0, en=1.
REQ-021 SHALL, in SOFTSTART, increment duty by 1 per tick; on the tick where duty+1 == SS_TARGET, enter REGULATE with duty=SS_TARGET.
REQ-022 SHALL, in REGULATE, on each tick decrement duty if fb=1 (saturate at DUTY_MIN) or increment if fb=0 (saturate at DUTY_MAX); fb ignored between ticks.
REQ-023 SHALL, on stop=1 in SOFTSTART or REGULATE, enter IDLE with duty=0, en=0 next cycle, discarding any same-cycle tick.
REQ-024 SHALL, on ocp=1 in IDLE, SOFTSTART or REGULATE, enter FAULT next cycle with duty=0, en=0, fault=1.
REQ-025 SHALL apply priority ocp > stop > start/tick when asserted in the same cycle.
REQ-026 SHALL remain in FAULT until fault_clr=1 and ocp=0 in the same cycle, then enter IDLE (fault=0); fault_clr with ocp=1 ignored.
REQ-027 SHALL ignore start outside IDLE; start held high through IDLE re-entry after stop with stop released restarts soft-start.
REQ-028 SHALL never output duty > DUTY_MAX, nor en=1 in IDLE or FAULT.

Reset
REQ-029 SHALL, while reset=1 at a clock edge, force state=IDLE, duty=0, en=0, fault=0, tick counter=0, overriding all inputs including ocp.
REQ-030 SHALL, on reset asserted mid-SOFTSTART/REGULATE/FAULT, return to IDLE on that edge; first transition possible the edge after reset deasserts.

Verification (TICK_DIV=4, SS_TARGET=8, DUTY_MIN=4, DUTY_MAX=12)
REQ-031 SHALL check soft-start: start pulse in IDLE -> en=1 next cycle, duty steps 0..8 every 4 cycles, state=2 at duty=8 after 32 cycles.
REQ-032 SHALL check clamps: REGULATE, fb=0 held 40 cycles -> duty rises to 12 and holds; fb=1 held 60 cycles -> duty falls to 4 and holds.
REQ-033 SHALL check fault: ocp=1 in REGULATE duty=10 -> next cycle state=3, duty=0, en=0, fault=1; fault_clr with ocp=1 -> stays FAULT; ocp=0 + fault_clr -> IDLE, fault=0.
REQ-034 SHALL check priority: ocp, stop and tick same cycle in SOFTSTART -> FAULT; stop and tick same cycle -> IDLE, duty=0.
REQ-035 SHALL check reset mid-operation: reset at duty=6 in SOFTSTART -> IDLE, duty=0, en=0, counter 0; start after release -> soft-start from duty=0 with full 4-cycle first tick.
